// File: rtl/aoi2222_bus_arbiter.sv
// Round-robin arbiter that time-shares one aoi2222 inverting AND-OR mux among four requesters.
// Grants are registered and one-hot, with a bounded hold time and a dead cycle between owners.
module aoi2222_bus_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned DPFLAG   = 0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   REQ,
    output logic [3:0]   GNT,
    output logic [N-1:0] SEL0,
    output logic [N-1:0] SEL1,
    output logic [N-1:0] SEL2,
    output logic [N-1:0] SEL3,
    output logic         BUSY,
    output logic [1:0]   OWNER
);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    localparam logic [7:0] CntMax = 8'(HOLD_MAX - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;

    logic [1:0] winner;
    logic [3:0] others;
    logic       release_own;

    // Cell-library compatibility flag; intentionally has no effect on the logic.
    if (DPFLAG != 0) begin : g_dpflag
    end

    // Circular search from ptr_q; descending loop so the nearest requester wins.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        others      = REQ & ~(4'b0001 << owner_q);
        release_own = !REQ[owner_q] || ((cnt_q == CntMax) && (others != 4'b0000));
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            StIdle, StTurn: begin
                gnt_d = 4'b0000;
                cnt_d = 8'd0;
                if (REQ != 4'b0000) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << winner;
                    owner_d = winner;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (release_own) begin
                    state_d = StTurn;
                    gnt_d   = 4'b0000;
                    ptr_d   = owner_q + 2'd1;
                    cnt_d   = 8'd0;
                end else if (cnt_q < CntMax) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= 8'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL0  = {N{gnt_q[0]}};
    assign SEL1  = {N{gnt_q[1]}};
    assign SEL2  = {N{gnt_q[2]}};
    assign SEL3  = {N{gnt_q[3]}};
    assign BUSY  = |gnt_q;
    assign OWNER = owner_q;

endmodule

// File: doc/aoi2222_bus_arbiter.md
Name: aoi2222_bus_arbiter

Overview:
- Round-robin arbiter that shares one N-bit aoi2222 inverting AND-OR mux among four requesters.
- Requester i drives IN(2i); this block drives the paired select legs IN1/IN3/IN5/IN7 through SEL0..SEL3.
- Grants are registered and one-hot, with a bounded hold time.
- One dead turnaround cycle is inserted between owners so two legs are never enabled together.

Parameters:
- N, 8, datapath width of the aoi2222 being controlled; width of each SELi output.
- HOLD_MAX, 4, maximum consecutive grant cycles under contention; legal range 1..255.
- DPFLAG, 0, kept for cell-library compatibility; no functional effect.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  4  REQ[i] = requester i wants the bus; held until granted and for the whole transfer.
- GNT  output  4  registered one-hot grant, or all zero.
- SEL0  output  N  {N{GNT[0]}}, drives aoi2222 IN1.
- SEL1  output  N  {N{GNT[1]}}, drives IN3.
- SEL2  output  N  {N{GNT[2]}}, drives IN5.
- SEL3  output  N  {N{GNT[3]}}, drives IN7.
- BUSY  output  1  high when GNT is non-zero.
- OWNER  output  2  index of the current or most recent grantee.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - GNT=0000, all SELi=0, BUSY=0, OWNER=0.
  - Priority pointer PTR=0, hold counter CNT=0, state IDLE.
  - With no leg selected, the aoi2222 output Y is all ones (idle bus value).
- Arbitration function: choose the first i with REQ[i]=1, searching circularly PTR, PTR+1, PTR+2, PTR+3 (mod 4).
- State IDLE: GNT=0.
  - If REQ≠0: next state GRANT; GNT gets one-hot(winner); OWNER=winner; CNT=0. REQ-to-GNT latency is 1 clock.
  - Else: stay in IDLE.
- State GRANT:
  - Let OTHERS = REQ with bit OWNER masked.
  - Release condition: REQ[OWNER]=0, OR (CNT==HOLD_MAX-1 AND OTHERS≠0).
  - On release: next state TURN; GNT=0; PTR=OWNER+1 mod 4; CNT=0.
  - Otherwise: hold GNT; CNT increments, saturating at HOLD_MAX-1.
  - With OTHERS=0 the owner keeps the bus indefinitely.
- State TURN: exactly one cycle with GNT=0 (break-before-make).
  - Arbitrate with the updated PTR.
  - If REQ≠0: next state GRANT with the new winner.
  - Else: next state IDLE.
- GNT is never anything other than one-hot or zero.
- SELi, BUSY and OWNER are all derived from registers; no combinational path from REQ to any output.
- Boundary cases:
  - REQ dropped before its grant: that requester is skipped.
  - Simultaneous release by the owner and new requests: still one TURN cycle, then the round-robin winner.
  - HOLD_MAX=1: under contention, the owner holds for 1 cycle, then TURN.
  - Owner drops REQ in the same cycle CNT saturates: normal release, PTR=OWNER+1.
  - PTR wraps 3→0.
- Guaranteed worst-case wait for a held request: 3×(HOLD_MAX+1) cycles after the current grant ends.

Test Plan:
- Reset/idle: assert RESET during an active grant with REQ=1111 → GNT=0000 and SEL0..3=0 immediately (before the next edge); the mux Y reads 0xFF for N=8.
- Single requester: REQ=0100 from cycle 0, held 10 cycles → GNT=0100 from cycle 1 to cycle 10, no forced release; REQ→0 → TURN cycle, then IDLE, GNT=0000.
- Round-robin contention: HOLD_MAX=4, REQ=1111 held → GNT sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001…
- Pointer fairness: owner 2 releases while REQ=1011 → after TURN, GNT=1000 (not 0001); the next release grants 0001.
- HOLD_MAX=1, REQ=0011 → GNT alternates 0001, 0000, 0010, 0000; BUSY toggles every cycle; SEL never has two legs set in any cycle.
- Withdrawn request: REQ=0110, requester 1 granted; requester 2 drops REQ before its turn → after requester 1 releases, state goes TURN→IDLE, GNT stays 0000, OWNER=1.
